// File: rtl/gfp8_group_accumulator_if.sv
// Group-result input stream and block-result output stream of gfp8_group_accumulator.
// The accumulator connects through the slave modport; the producer/consumer side uses master.
interface gfp8_group_accumulator_if #(
  parameter int ACC_WIDTH = 40
);
  logic                        i_valid;
  logic                        o_ready;
  logic signed [31:0]          i_mantissa;
  logic signed [7:0]           i_exponent;
  logic                        o_valid;
  logic                        i_ready;
  logic signed [ACC_WIDTH-1:0] o_mantissa;
  logic signed [7:0]           o_exponent;

  modport slave (
    input  i_valid, i_mantissa, i_exponent, i_ready,
    output o_ready, o_valid, o_mantissa, o_exponent
  );

  modport master (
    output i_valid, i_mantissa, i_exponent, i_ready,
    input  o_ready, o_valid, o_mantissa, o_exponent
  );
endinterface

// File: rtl/gfp8_group_accumulator.sv
// Aligns per-group GFP8 results to a running block exponent and sums GROUPS_PER_BLOCK of them.
// Optional macro GFP_ACC_ROUND_EN switches alignment from truncation to round-half-up.
module gfp8_group_accumulator #(
  parameter int GROUPS_PER_BLOCK = 4,
  parameter int ACC_WIDTH        = 40
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_clear,
  gfp8_group_accumulator_if.slave bus
);

  localparam int CountWidth = (GROUPS_PER_BLOCK > 1) ? $clog2(GROUPS_PER_BLOCK) : 1;
  localparam logic [CountWidth-1:0] LastCount = CountWidth'(GROUPS_PER_BLOCK - 1);

  typedef enum logic {ACCUM, HOLD} state_e;

  // Shift right by d; shifts past the accumulator width saturate to the sign (or zero when rounding).
  function automatic logic signed [ACC_WIDTH-1:0] alignFn(
    input logic signed [ACC_WIDTH-1:0] x,
    input logic [8:0]                  d
  );
    logic signed [ACC_WIDTH-1:0] result;
`ifdef GFP_ACC_ROUND_EN
    logic signed [ACC_WIDTH-1:0] halfShift;
    halfShift = '0;
    if (d == 9'd0) begin
      result = x;
    end else if ({23'd0, d} >= 32'(ACC_WIDTH)) begin
      result = '0;
    end else begin
      halfShift = x >>> (d - 9'd1);
      result    = (x >>> d) + {{(ACC_WIDTH-1){1'b0}}, halfShift[0]};
    end
`else
    if ({23'd0, d} >= 32'(ACC_WIDTH)) begin
      result = {ACC_WIDTH{x[ACC_WIDTH-1]}};
    end else begin
      result = x >>> d;
    end
`endif
    return result;
  endfunction

  state_e                      state_q, state_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic signed [7:0]           accExp_q, accExp_d;
  logic [CountWidth-1:0]       count_q, count_d;
  logic                        empty_q, empty_d;
  logic signed [ACC_WIDTH-1:0] outMant_q, outMant_d;
  logic signed [7:0]           outExp_q, outExp_d;

  logic                        accept;
  logic signed [ACC_WIDTH-1:0] mantExt;
  logic [8:0]                  expDiff;
  logic [8:0]                  expMag;
  logic                        newerExp;
  logic signed [ACC_WIDTH-1:0] sumAcc;
  logic signed [7:0]           sumExp;
  logic                        sumEmpty;

  assign bus.o_valid    = (state_q == HOLD);
  assign bus.o_ready    = (state_q != HOLD) || bus.i_ready;
  assign bus.o_mantissa = outMant_q;
  assign bus.o_exponent = outExp_q;

  assign accept   = bus.i_valid && bus.o_ready;
  assign mantExt  = ACC_WIDTH'(bus.i_mantissa);
  assign expDiff  = {bus.i_exponent[7], bus.i_exponent} - {accExp_q[7], accExp_q};
  assign expMag   = expDiff[8] ? (9'd0 - expDiff) : expDiff;
  assign newerExp = bus.i_exponent > accExp_q;

  // Post-add value of the block if the presented group were accepted this cycle.
  // A zero mantissa never moves the exponent, except that the block's first group seeds it.
  always_comb begin
    sumAcc   = acc_q;
    sumExp   = accExp_q;
    sumEmpty = empty_q;
    if (bus.i_mantissa == 32'sd0) begin
      if (empty_q && (count_q == '0)) begin
        sumExp = bus.i_exponent;
      end
    end else if (empty_q) begin
      sumAcc   = mantExt;
      sumExp   = bus.i_exponent;
      sumEmpty = 1'b0;
    end else if (newerExp) begin
      sumAcc = alignFn(acc_q, expMag) + mantExt;
      sumExp = bus.i_exponent;
    end else begin
      sumAcc = acc_q + alignFn(mantExt, expMag);
    end
  end

  // Block sequencing: the output register loads on the last group while the partial sum restarts.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    accExp_d  = accExp_q;
    count_d   = count_q;
    empty_d   = empty_q;
    outMant_d = outMant_q;
    outExp_d  = outExp_q;
    if (i_clear) begin
      state_d  = ACCUM;
      acc_d    = '0;
      accExp_d = '0;
      count_d  = '0;
      empty_d  = 1'b1;
    end else begin
      if ((state_q == HOLD) && bus.i_ready) begin
        state_d = ACCUM;
      end
      if (accept) begin
        if (count_q == LastCount) begin
          outMant_d = sumAcc;
          outExp_d  = sumExp;
          state_d   = HOLD;
          acc_d     = '0;
          accExp_d  = '0;
          count_d   = '0;
          empty_d   = 1'b1;
        end else begin
          acc_d    = sumAcc;
          accExp_d = sumExp;
          count_d  = count_q + 1'b1;
          empty_d  = sumEmpty;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= ACCUM;
      acc_q     <= '0;
      accExp_q  <= '0;
      count_q   <= '0;
      empty_q   <= 1'b1;
      outMant_q <= '0;
      outExp_q  <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      accExp_q  <= accExp_d;
      count_q   <= count_d;
      empty_q   <= empty_d;
      outMant_q <= outMant_d;
      outExp_q  <= outExp_d;
    end
  end

endmodule

// File: tb/tb_gfp8_group_accumulator.sv
// Self-checking bench for gfp8_group_accumulator: directed block scenarios followed by a
// randomized stream, compared every cycle against a transaction-level model of the block sum.
module tb_gfp8_group_accumulator;

   localparam int G  = 4;
   localparam int AW = 40;

   logic clk;
   logic rst_n;
   logic clear;

   int testCount;
   int failCount;

   // Reference model state: groups of the current partial block and the expected output register.
   longint grpMant[$];
   int     grpExp[$];
   bit     mValid;
   longint mMant;
   int     mExp;

   gfp8_group_accumulator_if #(.ACC_WIDTH(AW)) bus ();

   gfp8_group_accumulator #(
      .GROUPS_PER_BLOCK(G),
      .ACC_WIDTH       (AW)
   ) dut (
      .i_clk    (clk),
      .i_reset_n(rst_n),
      .i_clear  (clear),
      .bus      (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic longint floorDiv(input longint a, input longint b);
      longint q;
      q = a / b;
      if ((a % b) != 0 && a < 0) q = q - 1;
      return q;
   endfunction

   // Alignment as plain arithmetic: floor(x / 2^d), or floor(x / 2^d + 1/2) when rounding.
   function automatic longint alignModel(input longint x, input int d);
      longint p;
`ifdef GFP_ACC_ROUND_EN
      if (d == 0) return x;
      if (d >= AW) return 0;
      p = longint'(1) << d;
      return floorDiv(x + p / 2, p);
`else
      if (d >= AW) return (x < 0) ? -1 : 0;
      p = longint'(1) << d;
      return floorDiv(x, p);
`endif
   endfunction

   // Fold the collected groups of one block into its result.
   function automatic void blockResult(output longint m, output int e);
      longint acc;
      int     ex;
      bit     empty;
      acc = 0;
      ex = 0;
      empty = 1'b1;
      foreach (grpMant[i]) begin
         if (grpMant[i] == 0) begin
            if (i == 0) ex = grpExp[i];
         end else if (empty) begin
            acc = grpMant[i];
            ex = grpExp[i];
            empty = 1'b0;
         end else if (grpExp[i] > ex) begin
            acc = alignModel(acc, grpExp[i] - ex) + grpMant[i];
            ex = grpExp[i];
         end else begin
            acc = acc + alignModel(grpMant[i], ex - grpExp[i]);
         end
      end
      m = acc;
      e = ex;
   endfunction

   function automatic bit partialAllZero();
      foreach (grpMant[i]) if (grpMant[i] != 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic checkOutput(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      testCount++;
      assert (obs === exp)
      else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic checkDut(input string tag);
      checkOutput({tag, "_valid"}, 64'(bus.o_valid), 64'(mValid));
      checkOutput({tag, "_mant"}, bus.o_mantissa, mMant);
      checkOutput({tag, "_exp"}, bus.o_exponent, 64'(mExp));
      checkOutput({tag, "_ready"}, 64'(bus.o_ready), 64'(!mValid || bus.i_ready));
   endtask

   task automatic modelReset();
      grpMant.delete();
      grpExp.delete();
      mValid = 1'b0;
      mMant = 0;
      mExp = 0;
   endtask

   // One clock edge with the inputs currently driven; model follows the same edge.
   task automatic tick(input string tag);
      bit acceptNow;
      bit drainNow;
      bit clrNow;
      acceptNow = bus.i_valid && (!mValid || bus.i_ready);
      drainNow = mValid && bus.i_ready;
      clrNow = clear;
      @(posedge clk);
      #1;
      if (clrNow) begin
         grpMant.delete();
         grpExp.delete();
         mValid = 1'b0;
      end else begin
         if (drainNow) mValid = 1'b0;
         if (acceptNow) begin
            grpMant.push_back(longint'(bus.i_mantissa));
            grpExp.push_back(int'(bus.i_exponent));
            if (grpMant.size() == G) begin
               blockResult(mMant, mExp);
               mValid = 1'b1;
               grpMant.delete();
               grpExp.delete();
            end
         end
      end
      checkDut(tag);
   endtask

   task automatic applyStimulus(input bit v, input int m, input int e, input bit r, input bit c, input string tag);
      bus.i_valid = v;
      bus.i_mantissa = 32'(m);
      bus.i_exponent = 8'(e);
      bus.i_ready = r;
      clear = c;
      tick(tag);
   endtask

   task automatic asyncReset(input string tag);
      bus.i_valid = 1'b0;
      clear = 1'b0;
      rst_n = 1'b0;
      #1;
      modelReset();
      checkDut(tag);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkDut({tag, "_release"});
   endtask

   initial begin
      int m;
      int e;
      bit v;
      bit r;
      bit c;
      testCount = 0;
      failCount = 0;
      rst_n = 1'b0;
      clear = 1'b0;
      bus.i_valid = 1'b0;
      bus.i_mantissa = '0;
      bus.i_exponent = '0;
      bus.i_ready = 1'b1;
      modelReset();
      repeat (2) @(posedge clk);
      #1;
      checkDut("reset");
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkDut("reset_release");

      // Equal exponents
      applyStimulus(1, 100, 0, 1, 0, "eq_g0");
      applyStimulus(1, 200, 0, 1, 0, "eq_g1");
      applyStimulus(1, -50, 0, 1, 0, "eq_g2");
      applyStimulus(1, 10, 0, 1, 0, "eq_g3");
      checkOutput("eq_result_valid", 64'(bus.o_valid), 1);
      checkOutput("eq_result_mant", bus.o_mantissa, 260);
      checkOutput("eq_result_exp", bus.o_exponent, 0);
      applyStimulus(0, 0, 0, 1, 0, "eq_idle");
      checkOutput("eq_single_pulse", 64'(bus.o_valid), 0);

      // Alignment with an ignored zero-mantissa group
      applyStimulus(1, 64, 2, 1, 0, "al_g0");
      applyStimulus(1, 8, 5, 1, 0, "al_g1");
      applyStimulus(1, 0, 20, 1, 0, "al_g2");
      applyStimulus(1, -4, 5, 1, 0, "al_g3");
      checkOutput("al_result_mant", bus.o_mantissa, 12);
      checkOutput("al_result_exp", bus.o_exponent, 5);

      // Rounding and large shift
      applyStimulus(1, 12, 0, 1, 0, "rd_g0");
      applyStimulus(1, 1, 3, 1, 0, "rd_g1");
      applyStimulus(1, 0, 3, 1, 0, "rd_g2");
      applyStimulus(1, 0, 3, 1, 0, "rd_g3");
`ifdef GFP_ACC_ROUND_EN
      checkOutput("rd_result_mant", bus.o_mantissa, 3);
`else
      checkOutput("rd_result_mant", bus.o_mantissa, 2);
`endif
      checkOutput("rd_result_exp", bus.o_exponent, 3);
      applyStimulus(1, -5, 0, 1, 0, "ls_g0");
      applyStimulus(1, 1, 60, 1, 0, "ls_g1");
      applyStimulus(1, 0, 0, 1, 0, "ls_g2");
      applyStimulus(1, 0, 0, 1, 0, "ls_g3");
`ifdef GFP_ACC_ROUND_EN
      checkOutput("ls_result_mant", bus.o_mantissa, 1);
`else
      checkOutput("ls_result_mant", bus.o_mantissa, 0);
`endif
      checkOutput("ls_result_exp", bus.o_exponent, 60);

      // All-zero block keeps the first group's exponent
      for (int i = 0; i < G; i++) applyStimulus(1, 0, -9, 1, 0, "zero_blk");
      checkOutput("zero_blk_mant", bus.o_mantissa, 0);
      checkOutput("zero_blk_exp", bus.o_exponent, -9);

      // Backpressure: held result, stalled input, then drain and accept in one cycle
      applyStimulus(1, 7, 1, 0, 0, "bp_g0");
      applyStimulus(1, 9, 1, 0, 0, "bp_g1");
      applyStimulus(1, 3, 2, 0, 0, "bp_g2");
      applyStimulus(1, 5, 0, 0, 0, "bp_g3");
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1, 21, 3, 0, 0, "bp_stall");
         checkOutput("bp_stall_ready", 64'(bus.o_ready), 0);
      end
      applyStimulus(1, 21, 3, 1, 0, "bp_drain");
      checkOutput("bp_drain_valid", 64'(bus.o_valid), 0);
      applyStimulus(1, -6, 3, 1, 0, "bp_n1");
      applyStimulus(1, 1, 4, 1, 0, "bp_n2");
      applyStimulus(1, 2, 2, 1, 0, "bp_n3");
      applyStimulus(0, 0, 0, 1, 0, "bp_idle");

      // Clear mid-block drops the concurrent group and the partial sum
      applyStimulus(1, 5, 0, 1, 0, "cl_g0");
      applyStimulus(1, 6, 0, 1, 0, "cl_g1");
      applyStimulus(1, 99, 0, 1, 1, "cl_clear");
      for (int i = 0; i < G; i++) applyStimulus(1, 1, 0, 1, 0, "cl_next");
      checkOutput("cl_result_mant", bus.o_mantissa, 4);
      checkOutput("cl_result_exp", bus.o_exponent, 0);
      applyStimulus(0, 0, 0, 1, 0, "cl_idle");

      // Asynchronous reset mid-block and while a result is held
      for (int i = 0; i < 3; i++) applyStimulus(1, 9, 2, 1, 0, "ar_part");
      asyncReset("ar_count3");
      for (int i = 0; i < G; i++) applyStimulus(1, 3, 3, 0, 0, "ar_hold");
      asyncReset("ar_valid");
      for (int i = 0; i < G; i++) applyStimulus(1, -2, 7, 1, 0, "ar_next");
      checkOutput("ar_result_mant", bus.o_mantissa, -8);
      checkOutput("ar_result_exp", bus.o_exponent, 7);

      // Randomized stream
      for (int i = 0; i < 800; i++) begin
         v = ($urandom_range(9, 0) < 7);
         r = ($urandom_range(9, 0) < 7);
         c = ($urandom_range(39, 0) == 0);
         case ($urandom_range(4, 0))
            0: m = 0;
            1: m = int'($urandom_range(40, 0)) - 20;
            default: m = int'($urandom());
         endcase
         if ($urandom_range(1, 0) == 0) e = int'($urandom_range(255, 0)) - 128;
         else e = int'($urandom_range(6, 0)) - 3;
         if (m == 0 && grpMant.size() > 0 && partialAllZero()) e = grpExp[0];
         applyStimulus(v, m, e, r, c, "rand");
      end
      applyStimulus(0, 0, 0, 1, 0, "final_idle");

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
